// File: rtl/virgule_pkg.sv
// rtl/virgule_pkg.sv - shared types and constants for the Virgule core
//
// Purpose: word type, M-extension operation encoding, multiply/divide
// sequencer states and the operand signedness helpers used by muldiv_unit.
// Ports: none (package).

package virgule_pkg;

  typedef logic [31:0] word_t;

  // Encoded as RV32M funct3.
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_fn_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } muldiv_state_t;

  localparam int muldiv_steps = 32;

  // funct7 that selects the M extension under opcode OP.
  localparam logic [6:0] funct7_muldiv = 7'b0000001;

  // MUL only needs the low product word, which is identical for signed and
  // unsigned operands, so it is handled as unsigned.
  function automatic logic xs1_is_signed(muldiv_fn_t f);
    return f inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic xs2_is_signed(muldiv_fn_t f);
    return f inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M multiply/divide execution unit
//
// Purpose: shift-add multiply and restoring divide on operand magnitudes,
// 32 iterations through one shared 33-bit adder, then one sign-fix cycle.
// Constant 33-cycle latency for every operation.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          request; fn/xs1/xs2 sampled when idle
//   fn             operation (RV32M funct3)
//   xs1, xs2       operands from register_unit
//   busy           operation in progress, start ignored
//   done           one-cycle pulse, result valid from this cycle
//   result         result, held until the next operation completes

module muldiv_unit
  import virgule_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  muldiv_fn_t fn,
  input  word_t      xs1,
  input  word_t      xs2,
  output logic       busy,
  output logic       done,
  output word_t      result
);

  muldiv_state_t state_q, state_d;
  muldiv_fn_t    fn_q;
  logic          neg_a_q, neg_b_q;
  word_t         hi_q, lo_q, b_q;
  logic [4:0]    count_q;

  logic  xs1_neg, xs2_neg;
  word_t xs1_mag, xs2_mag;
  logic  is_div;

  assign xs1_neg = xs1_is_signed(fn) & xs1[31];
  assign xs2_neg = xs2_is_signed(fn) & xs2[31];
  assign xs1_mag = xs1_neg ? -xs1 : xs1;
  assign xs2_mag = xs2_neg ? -xs2 : xs2;
  assign is_div  = fn_q[2];

  // Shared adder: multiply adds the multiplier to hi when lo[0] is set;
  // divide subtracts the divisor from the left-shifted {hi, lo[31]}.
  logic [32:0] add_a, add_b, add_sum;
  logic        add_cin;
  logic        commit;

  always_comb begin
    add_a   = {1'b0, hi_q};
    add_b   = lo_q[0] ? {1'b0, b_q} : 33'd0;
    add_cin = 1'b0;
    if (is_div) begin
      add_a   = {hi_q, lo_q[31]};
      add_b   = ~{1'b0, b_q};
      add_cin = 1'b1;
    end
  end

  assign add_sum = add_a + add_b + {32'd0, add_cin};
  // A shifted partial remainder with bit 32 set already exceeds any divisor,
  // so the wrapped sign bit of the difference is only meaningful otherwise.
  assign commit  = add_a[32] | ~add_sum[32];

  // Sign correction. A zero divisor leaves hi = |xs1| and lo = all ones, so
  // the remainder comes out as xs1 naturally; only the quotient is forced.
  logic [63:0] prod, prod_fix;
  word_t       quot, rem, fix_result;

  assign prod     = {hi_q, lo_q};
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
  assign quot     = (b_q == '0) ? '1 : ((neg_a_q ^ neg_b_q) ? -lo_q : lo_q);
  assign rem      = neg_a_q ? -hi_q : hi_q;

  always_comb begin
    fix_result = rem;
    case (fn_q)
      MUL:                  fix_result = prod_fix[31:0];
      MULH, MULHSU, MULHU:  fix_result = prod_fix[63:32];
      DIV, DIVU:            fix_result = quot;
      default:              fix_result = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (count_q == 5'(muldiv_steps - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fn_q    <= MUL;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      count_q <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            fn_q    <= fn;
            neg_a_q <= xs1_neg;
            neg_b_q <= xs2_neg;
            hi_q    <= '0;
            lo_q    <= xs1_mag;
            b_q     <= xs2_mag;
            count_q <= '0;
          end
        end
        RUN: begin
          count_q <= count_q + 5'd1;
          if (is_div) begin
            hi_q <= commit ? add_sum[31:0] : {hi_q[30:0], lo_q[31]};
            lo_q <= {lo_q[30:0], commit};
          end else begin
            hi_q <= add_sum[32:1];
            lo_q <= {add_sum[0], lo_q[31:1]};
          end
        end
        FIX: begin
          result <= fix_result;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit

module tb_muldiv_unit;
  import virgule_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  muldiv_fn_t fn = MUL;
  word_t      xs1 = '0;
  word_t      xs2 = '0;
  logic       busy;
  logic       done;
  word_t      result;

  int checks = 0;
  int failures = 0;
  word_t exp_q[$];

  typedef struct {
    muldiv_fn_t f;
    word_t      a;
    word_t      b;
    word_t      e;
  } op_t;
  op_t ops[$];

  muldiv_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .fn     (fn),
    .xs1    (xs1),
    .xs2    (xs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pops the oldest expected result.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  function automatic void add_op(muldiv_fn_t f, word_t a, word_t b, word_t e);
    op_t o;
    o.f = f; o.a = a; o.b = b; o.e = e;
    ops.push_back(o);
  endfunction

  // Called at a negedge while idle; returns just after the accepting edge.
  task automatic issue(input muldiv_fn_t f, input word_t a, input word_t b, input word_t e,
                       input bit expect_it);
    start = 1'b1;
    fn    = f;
    xs1   = a;
    xs2   = b;
    if (expect_it) exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    xs1   = $urandom;
    xs2   = $urandom;
    fn    = muldiv_fn_t'($urandom_range(7));
  endtask

  // k counts edges after the accepting edge; done must appear at k = 33.
  task automatic wait_done(input string tag);
    int k;
    int busy_n;
    busy_n = 0;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_n++;
    end
    check({tag, "_latency"}, k, 33);
    check({tag, "_busy_cycles"}, busy_n, 33);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int k;
    int unstable;
    int stray;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(MUL, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 1'b1);
    wait_done("mul_basic");
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);

    add_op(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    add_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    add_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    add_op(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    add_op(MULHU,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001);
    add_op(DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    add_op(REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    add_op(DIVU,   32'h0000_0007, 32'h0000_0002, 32'h0000_0003);
    add_op(REMU,   32'h0000_0007, 32'h0000_0002, 32'h0000_0001);
    add_op(DIV,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    add_op(DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    add_op(REM,    32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
    add_op(REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
    add_op(DIV,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF);
    add_op(REM,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB);
    add_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    add_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    add_op(DIVU,   32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001);
    add_op(REMU,   32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF);
    add_op(MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF);

    foreach (ops[i]) begin
      issue(ops[i].f, ops[i].a, ops[i].b, ops[i].e, 1'b1);
      wait_done($sformatf("op%0d", i));
      @(negedge clk);
    end

    // start held high with changing operands; re-issue in the done cycle.
    start = 1'b1;
    fn    = MUL;
    xs1   = 32'd3;
    xs2   = 32'd5;
    exp_q.push_back(32'd15);
    @(posedge clk);
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) break;
      xs1 = $urandom;
      xs2 = $urandom;
      fn  = muldiv_fn_t'($urandom_range(7));
    end
    check("held_start_latency", k, 33);
    fn  = DIVU;
    xs1 = 32'd100;
    xs2 = 32'd7;
    exp_q.push_back(32'd14);
    @(posedge clk);
    #1;
    start = 1'b0;
    unstable = 0;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) break;
      if (result !== 32'd15) unstable++;
    end
    check("back_to_back_gap", k, 33);
    check("result_stable", unstable, 0);

    // Reset mid-operation, with start also high during reset.
    @(negedge clk);
    issue(MUL, 32'h0000_0011, 32'h0000_0022, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    @(posedge clk);
    #1;
    check("reset_over_start", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    stray = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done) stray++;
    end
    check("no_done_after_reset", stray, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
